fetch_queue_stage: RTL



---
 rtl/fetch_queue_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// Fetch front end: PC generation, 1-cycle imem, DEPTH-entry queue to decode.
// Optional FETCH_PERF_CNT_EN adds saturating redirect/stall counters.
module fetch_queue_stage #(
  parameter int ISIZE = 16,
  parameter int DSIZE = 16,
  parameter int DEPTH = 4,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ISIZE-1:0] imem_addr,
  output logic             imem_req,
  input  logic [DSIZE-1:0] imem_data,
  input  logic             redirect,
  input  logic [ISIZE-1:0] redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [DSIZE-1:0] id_inst,
  output logic [ISIZE-1:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]      redirect_cnt,
  output logic [15:0]      stall_cnt,
`endif
  output logic [ISIZE-1:0] id_nextpc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FULL
  } state_t;

  state_t state, state_nxt;

  logic [ISIZE-1:0] fetch_pc;
  logic [ISIZE-1:0] tag_pc;
  logic             inflight;

  logic [DSIZE-1:0] inst_q [DEPTH];
  logic [ISIZE-1:0] pc_q [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;

  logic [AW+1:0]    used;
  logic [AW+1:0]    used_nxt;
  logic             credit;
  logic             issue;
  logic             push;
  logic             pop;

  // Credit counts entries held plus the one response still on the way.
  assign used   = (AW+2)'(count) + (AW+2)'(inflight);
  assign credit = used < CAP;
  assign issue  = (state == RUN) && !redirect && credit;
  assign push   = inflight && !redirect;
  assign pop    = id_valid && id_ready;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  assign id_valid  = (count != '0) && !redirect;
  assign id_inst   = inst_q[rd_ptr];
  assign id_pc     = pc_q[rd_ptr];
  assign id_nextpc = id_pc + ISIZE'(1);

  always_comb begin
    count_nxt = count;
    if (redirect) begin
      count_nxt = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_nxt = count + (AW+1)'(1);
        2'b01:   count_nxt = count - (AW+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  assign used_nxt = (AW+2)'(count_nxt) + (AW+2)'(issue);

  // RUN/FULL track the credit the next cycle will see, so no bubble.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN, FULL: begin
        if (redirect) begin
          state_nxt = RUN;
        end else if (used_nxt < CAP) begin
          state_nxt = RUN;
        end else begin
          state_nxt = FULL;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + ISIZE'(1);
        tag_pc   <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      inst_q[wr_ptr] <= imem_data;
      pc_q[wr_ptr]   <= tag_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (redirect && (redirect_cnt != 16'hFFFF)) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
      if (id_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
